muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/rv32im_pkg.sv | 31 +++
 rtl/div_radix8_step.sv | 28 ++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32IM constants: M-extension aluop codes and multiply/divide stall
// lengths, used by both the decoder and muldiv_unit so the two always agree.
package rv32im_pkg;

  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHU  = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  localparam int MUL_STALL_CYCLES = 3;
  localparam int DIV_STALL_CYCLES = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_MULHSU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/div_radix8_step.sv
// One radix-8 restoring division step: three binary restore sub-steps that
// shift in three dividend bits and produce three quotient bits.
module div_radix8_step (
  input  logic [31:0] rem_in,
  input  logic [2:0]  dvd_bits,
  input  logic [31:0] divisor,
  output logic [2:0]  q_bits,
  output logic [31:0] rem_out
);

  logic [32:0] r;

  // The incoming remainder is below the divisor, so it never needs more than
  // 33 bits after shifting in one dividend bit.
  always_comb begin
    r      = {1'b0, rem_in};
    q_bits = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      r = {r[31:0], dvd_bits[i]};
      if (r >= {1'b0, divisor}) begin
        r         = r - {1'b0, divisor};
        q_bits[i] = 1'b1;
      end
    end
    rem_out = r[31:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 3-cycle pipelined magnitude multiplier and an
// 11-cycle radix-8 restoring divider sharing one control FSM.
//
// state | meaning
// IDLE  | waiting for start; also the done cycle of the previous operation
// MUL   | partial products registered each cycle, result formed at cnt==1
// DIV   | one radix-8 step per cycle, sign fix-up applied at cnt==1
module muldiv_unit
  import rv32im_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_STALL_CYCLES,
  parameter int DIV_CYCLES = DIV_STALL_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  aluop,
  input  logic [31:0] portA,
  input  logic [31:0] portB,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [4:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] mag_a_q;
  logic [31:0] mag_b_q;
  logic        neg_q;
  logic        rem_neg_q;
  logic [29:0] dvd_q;
  logic [28:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;

  logic        a_signed, b_signed, sa, sb;
  logic [31:0] mag_a, mag_b;

  assign a_signed = aluop inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign b_signed = aluop inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign sa       = a_signed & portA[31];
  assign sb       = b_signed & portB[31];
  assign mag_a    = sa ? (~portA + 32'd1) : portA;
  assign mag_b    = sb ? (~portB + 32'd1) : portB;

  // The first division step runs in the start cycle straight from the ports,
  // which is what lets 11 steps fit into an 11-cycle latency.
  logic [31:0] step_rem_in, step_div, step_rem;
  logic [2:0]  step_bits, step_q;

  assign step_rem_in = (state == DIV) ? rem_q : 32'd0;
  assign step_bits   = (state == DIV) ? dvd_q[29:27] : {1'b0, mag_a[31:30]};
  assign step_div    = (state == DIV) ? mag_b_q : mag_b;

  div_radix8_step u_step (
    .rem_in   (step_rem_in),
    .dvd_bits (step_bits),
    .divisor  (step_div),
    .q_bits   (step_q),
    .rem_out  (step_rem)
  );

  logic [63:0] prod_mag, prod;
  logic [31:0] mul_res;

  assign prod_mag = {32'd0, pp_ll}
                  + ({32'd0, pp_lh} << 16)
                  + ({32'd0, pp_hl} << 16)
                  + {pp_hh, 32'd0};
  assign prod     = neg_q ? (~prod_mag + 64'd1) : prod_mag;
  assign mul_res  = (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];

  logic [31:0] quo_mag, quo, remv, div_res;
  logic        div_by_zero;

  assign quo_mag     = {quo_q, step_q};
  assign quo         = neg_q ? (~quo_mag + 32'd1) : quo_mag;
  assign remv        = rem_neg_q ? (~step_rem + 32'd1) : step_rem;
  assign div_by_zero = (mag_b_q == 32'd0);

  always_comb begin
    div_res = quo;
    if (op_q inside {ALU_DIV, ALU_DIVU}) begin
      div_res = div_by_zero ? 32'hFFFF_FFFF : quo;
    end else begin
      div_res = div_by_zero ? a_q : remv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      op_q      <= 5'd0;
      a_q       <= 32'd0;
      mag_a_q   <= 32'd0;
      mag_b_q   <= 32'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dvd_q     <= 30'd0;
      quo_q     <= 29'd0;
      rem_q     <= 32'd0;
      pp_ll     <= 32'd0;
      pp_lh     <= 32'd0;
      pp_hl     <= 32'd0;
      pp_hh     <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (is_mul_op(aluop) || is_div_op(aluop))) begin
            op_q      <= aluop;
            a_q       <= portA;
            mag_a_q   <= mag_a;
            mag_b_q   <= mag_b;
            neg_q     <= sa ^ sb;
            rem_neg_q <= sa;
            busy      <= 1'b1;
            if (is_mul_op(aluop)) begin
              state <= MUL;
              cnt   <= 4'(MUL_CYCLES - 1);
            end else begin
              state <= DIV;
              cnt   <= 4'(DIV_CYCLES - 1);
              rem_q <= step_rem;
              quo_q <= {26'd0, step_q};
              dvd_q <= mag_a[29:0];
            end
          end
        end
        MUL: begin
          pp_ll <= {16'd0, mag_a_q[15:0]}  * {16'd0, mag_b_q[15:0]};
          pp_lh <= {16'd0, mag_a_q[15:0]}  * {16'd0, mag_b_q[31:16]};
          pp_hl <= {16'd0, mag_a_q[31:16]} * {16'd0, mag_b_q[15:0]};
          pp_hh <= {16'd0, mag_a_q[31:16]} * {16'd0, mag_b_q[31:16]};
          if (cnt == 4'd1) begin
            result <= mul_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
            cnt    <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DIV: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[25:0], step_q};
          dvd_q <= {dvd_q[26:0], 3'b000};
          if (cnt == 4'd1) begin
            result <= div_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
            cnt    <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import rv32im_pkg::*;

  localparam int MUL_N = 3;
  localparam int DIV_N = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  aluop = 5'd0;
  logic [31:0] portA = 32'd0;
  logic [31:0] portB = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] exp_hold = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .aluop  (aluop),
    .portA  (portA),
    .portB  (portB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ub_s = ub;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = 64'd0;
    case (op)
      5'd10: begin p = sa * sb;   return p[31:0];  end
      5'd11: begin p = sa * sb;   return p[63:32]; end
      5'd12: begin p = ua * ub;   return p[63:32]; end
      5'd13: begin p = sa * ub_s; return p[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      5'd15: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      5'd16: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      5'd17: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one start pulse; caller is at a negedge with the DUT idle or in its done cycle.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_const, input logic [31:0] cval);
    exp_t e;
    start = 1'b1;
    aluop = op;
    portA = a;
    portB = b;
    if (op >= 5'd10 && op <= 5'd17) begin
      e.res = use_const ? cval : ref_model(op, a, b);
      e.cyc = cyc + ((op <= 5'd13) ? MUL_N : DIV_N);
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    aluop = 5'($urandom);
    portA = $urandom;
    portB = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops on done, otherwise checks the result is being held.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got result %h at cycle %0d, expected no done", result, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (result !== e.res || cyc != e.cyc) begin
            fails++;
            $display("FAIL sb_result: got %h at cycle %0d, expected %h at cycle %0d",
                     result, cyc, e.res, e.cyc);
          end
          exp_hold = e.res;
        end
      end else begin
        tests++;
        if (result !== exp_hold) begin
          fails++;
          $display("FAIL result_hold: got %h expected %h", result, exp_hold);
        end
      end
    end
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    int          n;

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 * -3 with busy profile
    issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
    chk("mul_busy_c1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("mul_busy_c2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("mul_busy_c3", {31'd0, busy}, 32'd0);
    chk("mul_done_c3", {31'd0, done}, 32'd1);
    @(negedge clk);

    issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    wait_idle();
    issue(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
    wait_idle();
    @(negedge clk);

    // DIV then REM back-to-back in the done cycle
    issue(ALU_DIV, 32'hFFFF_FFEC, 32'd3, 1'b1, 32'hFFFF_FFFA);
    wait_idle();
    chk("div_done_b2b", {31'd0, done}, 32'd1);
    issue(ALU_REM, 32'hFFFF_FFEC, 32'd3, 1'b1, 32'hFFFF_FFFE);
    wait_idle();

    issue(ALU_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF);
    wait_idle();
    issue(ALU_REMU, 32'd5, 32'd0, 1'b1, 32'd5);
    wait_idle();
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    wait_idle();
    issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
    wait_idle();

    // start while busy must be ignored
    issue(ALU_DIV, 32'd100, 32'd7, 1'b1, 32'd14);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      aluop = ALU_MUL;
      portA = $urandom;
      portB = $urandom;
      @(negedge clk);
      chk("busy_ignore", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    wait_idle();

    // unsupported aluop is ignored
    issue(5'd3, 32'd9, 32'd9, 1'b0, 32'd0);
    chk("bad_op_busy", {31'd0, busy}, 32'd0);
    issue(5'd20, 32'd9, 32'd9, 1'b0, 32'd0);
    chk("bad_op_busy2", {31'd0, busy}, 32'd0);

    // randomized traffic, including back-to-back issue
    for (int i = 0; i < 60; i++) begin
      wait_idle();
      n = $urandom_range(0, 3);
      if (n == 3) @(negedge clk);
      a = pick_operand();
      b = pick_operand();
      if ($urandom_range(0, 7) == 0) begin
        op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(18, 31));
        issue(op, a, b, 1'b0, 32'd0);
        chk("rand_bad_op_busy", {31'd0, busy}, 32'd0);
      end else begin
        op = 5'($urandom_range(10, 17));
        issue(op, a, b, 1'b0, 32'd0);
        chk("rand_busy", {31'd0, busy}, 32'd1);
      end
    end
    wait_idle();
    @(negedge clk);

    // reset in cycle 5 of a DIV aborts it
    issue(ALU_DIV, 32'd1000, 32'd3, 1'b1, 32'd333);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    exp_hold = 32'd0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    issue(ALU_MULHU, 32'h0001_0000, 32'h0003_0000, 1'b1, 32'd3);
    chk("first_edge_start", {31'd0, busy}, 32'd1);
    wait_idle();
    repeat (15) @(negedge clk);

    n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
